// File: rtl/ay8_fetch_sequencer_if.sv
// Request/ready memory read port between the AY8 fetch sequencer (master) and program memory (slave).
interface ay8_fetch_sequencer_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (output mem_req, mem_addr, input  mem_rdata, mem_ready);
  modport slave  (input  mem_req, mem_addr, output mem_rdata, mem_ready);
endinterface

// File: rtl/ay8_fetch_sequencer.sv
// AY8 instruction-fetch sequencer: request/ready fetch loop decoding NOP, JMP imm and HLT.
// Define AY8_FETCH_TIMEOUT_EN to bound memory waits by TIMEOUT cycles and trap into a sticky ERR state.
//
// state     | meaning
// S_IDLE    | stopped at an instruction boundary, waiting for run
// S_FETCH   | requesting opcode at pc
// S_DECODE  | instr_valid strobe, opcode dispatch
// S_OPERAND | requesting JMP target at pc
// S_HALT    | HLT executed, sticky until reset
// S_ERR     | memory wait timed out, sticky until reset (timeout build only)
module ay8_fetch_sequencer #(
  parameter int unsigned       ADDR_W   = 8,
  parameter int unsigned       DATA_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       TIMEOUT  = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  run,
  ay8_fetch_sequencer_if.master mem,
  output logic [DATA_W-1:0]     instr,
  output logic                  instr_valid,
  output logic [ADDR_W-1:0]     pc,
  output logic                  halted,
  output logic                  err
);

  localparam logic [7:0] OP_JMP = 8'h01;
  localparam logic [7:0] OP_HLT = 8'hFF;

`ifdef AY8_FETCH_TIMEOUT_EN
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_OPERAND, S_HALT, S_ERR
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_OPERAND, S_HALT
  } state_t;
`endif

  state_t            state_q, state_nxt;
  logic [ADDR_W-1:0] pc_q, pc_nxt;
  logic [DATA_W-1:0] ir_q, ir_nxt;
  logic              req;
  logic [ADDR_W-1:0] jmp_target;

  // JMP operand is zero-extended when the address is wider than the data word
  if (ADDR_W > DATA_W) begin : g_zext
    assign jmp_target = {{(ADDR_W - DATA_W){1'b0}}, mem.mem_rdata};
  end else begin : g_trunc
    assign jmp_target = mem.mem_rdata[ADDR_W-1:0];
  end

`ifdef AY8_FETCH_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wait_cnt;
  logic             wait_expired;

  // Any cycle without an outstanding wait (idle, decode, or a completing access) restarts the count
  always_ff @(posedge CLK) begin
    if (RST) begin
      wait_cnt <= '0;
    end else if (req && !mem.mem_ready) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end else begin
      wait_cnt <= '0;
    end
  end

  assign wait_expired = (wait_cnt == CNT_W'(TIMEOUT - 1));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
    end else begin
      state_q <= state_nxt;
      pc_q    <= pc_nxt;
      ir_q    <= ir_nxt;
    end
  end

  always_comb begin
    state_nxt   = state_q;
    pc_nxt      = pc_q;
    ir_nxt      = ir_q;
    req         = 1'b0;
    instr_valid = 1'b0;
    halted      = 1'b0;
    err         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        req = 1'b1;
        if (mem.mem_ready) begin
          ir_nxt    = mem.mem_rdata;
          pc_nxt    = pc_q + ADDR_W'(1);
          state_nxt = S_DECODE;
        end
`ifdef AY8_FETCH_TIMEOUT_EN
        else if (wait_expired) begin
          state_nxt = S_ERR;
        end
`endif
      end
      S_DECODE: begin
        instr_valid = 1'b1;
        if (ir_q[7:0] == OP_HLT) begin
          state_nxt = S_HALT;
        end else if (ir_q[7:0] == OP_JMP) begin
          state_nxt = S_OPERAND;
        end else begin
          state_nxt = run ? S_FETCH : S_IDLE;
        end
      end
      S_OPERAND: begin
        req = 1'b1;
        if (mem.mem_ready) begin
          pc_nxt    = jmp_target;
          state_nxt = run ? S_FETCH : S_IDLE;
        end
`ifdef AY8_FETCH_TIMEOUT_EN
        else if (wait_expired) begin
          state_nxt = S_ERR;
        end
`endif
      end
      S_HALT: begin
        halted = 1'b1;
      end
`ifdef AY8_FETCH_TIMEOUT_EN
      S_ERR: begin
        err = 1'b1;
      end
`endif
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign mem.mem_req  = req;
  assign mem.mem_addr = pc_q;
  assign instr        = ir_q;
  assign pc           = pc_q;

endmodule

// File: tb/tb_ay8_fetch_sequencer.sv
// Directed self-checking bench for ay8_fetch_sequencer: fetch loop, wait states, JMP, wrap/stop, reset, timeout.
module tb_ay8_fetch_sequencer;

  logic       CLK;
  logic       RST;
  logic       run;
  logic       run2;
  logic [7:0] instr, instr2;
  logic       instr_valid, instr_valid2;
  logic [7:0] pc, pc2;
  logic       halted, halted2;
  logic       err, err2;

  int errors = 0;
  int checks = 0;

  logic [7:0] mem [256];
  int         lat;
  logic       ready_en;
  logic       ready_force;
  int         wcnt;

  ay8_fetch_sequencer_if #(.ADDR_W(8), .DATA_W(8)) bus1 ();
  ay8_fetch_sequencer_if #(.ADDR_W(8), .DATA_W(8)) bus2 ();

  ay8_fetch_sequencer #(.ADDR_W(8), .DATA_W(8), .RESET_PC(8'h00), .TIMEOUT(16)) u_dut (
    .CLK(CLK), .RST(RST), .run(run), .mem(bus1.master),
    .instr(instr), .instr_valid(instr_valid), .pc(pc), .halted(halted), .err(err)
  );

  ay8_fetch_sequencer #(.ADDR_W(8), .DATA_W(8), .RESET_PC(8'hFE), .TIMEOUT(16)) u_dut_wrap (
    .CLK(CLK), .RST(RST), .run(run2), .mem(bus2.master),
    .instr(instr2), .instr_valid(instr_valid2), .pc(pc2), .halted(halted2), .err(err2)
  );

  // Memory model: ready after `lat` wait cycles of a request, or forced
  assign bus1.mem_rdata = mem[bus1.mem_addr];
  assign bus1.mem_ready = ready_force | (ready_en && bus1.mem_req && (wcnt >= lat));
  assign bus2.mem_rdata = 8'h00;
  assign bus2.mem_ready = 1'b1;

  always @(posedge CLK) begin
    if (!bus1.mem_req || bus1.mem_ready) wcnt <= 0;
    else                                 wcnt <= wcnt + 1;
  end

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    run = 1'b0;
    run2 = 1'b0;
    ready_force = 1'b0;
    tick();
    RST = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus1.mem_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", bus1.mem_req); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", instr_valid); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got=%b exp=0", halted); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
    checks++; if (pc !== 8'h00) begin errors++; $display("FAIL reset_pc got=%h exp=00", pc); end
    checks++; if (instr !== 8'h00) begin errors++; $display("FAIL reset_ir got=%h exp=00", instr); end
    checks++; if (pc2 !== 8'hFE) begin errors++; $display("FAIL reset_pc_wrap got=%h exp=fe", pc2); end
  endtask

  task automatic test_basic();
    logic       exp_req;
    logic [7:0] exp_ir;
    clear_mem();
    mem[2] = 8'hFF;
    lat = 0;
    ready_en = 1'b1;
    do_reset();
    run = 1'b1;
    // Even cycles FETCH addr i/2, odd cycles DECODE with pc = i/2+1
    for (int i = 0; i < 6; i++) begin
      tick();
      exp_req = (i % 2 == 0);
      checks++; if (bus1.mem_req !== exp_req) begin errors++; $display("FAIL basic_req cyc=%0d got=%b exp=%b", i, bus1.mem_req, exp_req); end
      checks++; if (instr_valid !== !exp_req) begin errors++; $display("FAIL basic_valid cyc=%0d got=%b exp=%b", i, instr_valid, !exp_req); end
      if (exp_req) begin
        checks++; if (bus1.mem_addr !== 8'(i / 2)) begin errors++; $display("FAIL basic_addr cyc=%0d got=%h exp=%h", i, bus1.mem_addr, 8'(i / 2)); end
      end else begin
        exp_ir = (i == 5) ? 8'hFF : 8'h00;
        checks++; if (instr !== exp_ir) begin errors++; $display("FAIL basic_ir cyc=%0d got=%h exp=%h", i, instr, exp_ir); end
        checks++; if (pc !== 8'(i / 2 + 1)) begin errors++; $display("FAIL basic_pc cyc=%0d got=%h exp=%h", i, pc, 8'(i / 2 + 1)); end
      end
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (halted !== 1'b1) begin errors++; $display("FAIL basic_halted cyc=%0d got=%b exp=1", i, halted); end
      checks++; if (bus1.mem_req !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("FAIL basic_halt_quiet cyc=%0d req=%b valid=%b exp=0,0", i, bus1.mem_req, instr_valid); end
      checks++; if (pc !== 8'h03) begin errors++; $display("FAIL basic_final_pc got=%h exp=03", pc); end
    end
    run = 1'b0;
  endtask

  task automatic test_wait_states();
    clear_mem();
    mem[0] = 8'h5A;
    mem[1] = 8'hFF;
    lat = 3;
    ready_en = 1'b1;
    do_reset();
    run = 1'b1;
    for (int a = 0; a < 2; a++) begin
      for (int c = 0; c < 4; c++) begin
        tick();
        checks++; if (bus1.mem_req !== 1'b1) begin errors++; $display("FAIL wait_req addr=%0d cyc=%0d got=%b exp=1", a, c, bus1.mem_req); end
        checks++; if (bus1.mem_addr !== 8'(a)) begin errors++; $display("FAIL wait_addr cyc=%0d got=%h exp=%h", c, bus1.mem_addr, 8'(a)); end
        checks++; if (instr !== ((a == 0) ? 8'h00 : 8'h5A)) begin errors++; $display("FAIL wait_ir_hold addr=%0d cyc=%0d got=%h", a, c, instr); end
      end
      tick();
      checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL wait_valid addr=%0d got=%b exp=1", a, instr_valid); end
      checks++; if (instr !== ((a == 0) ? 8'h5A : 8'hFF)) begin errors++; $display("FAIL wait_ir addr=%0d got=%h", a, instr); end
      checks++; if (pc !== 8'(a + 1)) begin errors++; $display("FAIL wait_pc addr=%0d got=%h exp=%h", a, pc, 8'(a + 1)); end
    end
    tick();
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL wait_halted got=%b exp=1", halted); end
    run = 1'b0;
    lat = 0;
  endtask

  task automatic test_jump();
    clear_mem();
    mem[8'h00] = 8'h01;
    mem[8'h01] = 8'h10;
    mem[8'h10] = 8'hFF;
    lat = 0;
    ready_en = 1'b1;
    do_reset();
    run = 1'b1;
    tick();
    checks++; if (bus1.mem_req !== 1'b1 || bus1.mem_addr !== 8'h00) begin errors++; $display("FAIL jmp_fetch0 req=%b addr=%h exp=1,00", bus1.mem_req, bus1.mem_addr); end
    tick();
    checks++; if (instr_valid !== 1'b1 || instr !== 8'h01) begin errors++; $display("FAIL jmp_decode valid=%b ir=%h exp=1,01", instr_valid, instr); end
    tick();
    checks++; if (bus1.mem_req !== 1'b1 || bus1.mem_addr !== 8'h01 || instr_valid !== 1'b0) begin errors++; $display("FAIL jmp_operand req=%b addr=%h valid=%b exp=1,01,0", bus1.mem_req, bus1.mem_addr, instr_valid); end
    tick();
    checks++; if (bus1.mem_req !== 1'b1 || bus1.mem_addr !== 8'h10 || instr_valid !== 1'b0) begin errors++; $display("FAIL jmp_target req=%b addr=%h valid=%b exp=1,10,0", bus1.mem_req, bus1.mem_addr, instr_valid); end
    checks++; if (instr !== 8'h01) begin errors++; $display("FAIL jmp_ir_kept got=%h exp=01", instr); end
    tick();
    checks++; if (instr_valid !== 1'b1 || instr !== 8'hFF) begin errors++; $display("FAIL jmp_hlt_decode valid=%b ir=%h exp=1,ff", instr_valid, instr); end
    tick();
    checks++; if (halted !== 1'b1 || pc !== 8'h11) begin errors++; $display("FAIL jmp_final halted=%b pc=%h exp=1,11", halted, pc); end
    run = 1'b0;
  endtask

  task automatic test_wrap_stop();
    do_reset();
    run2 = 1'b1;
    tick();
    checks++; if (bus2.mem_req !== 1'b1 || bus2.mem_addr !== 8'hFE) begin errors++; $display("FAIL wrap_fe req=%b addr=%h exp=1,fe", bus2.mem_req, bus2.mem_addr); end
    tick();
    checks++; if (instr_valid2 !== 1'b1 || pc2 !== 8'hFF) begin errors++; $display("FAIL wrap_dec_fe valid=%b pc=%h exp=1,ff", instr_valid2, pc2); end
    tick();
    checks++; if (bus2.mem_req !== 1'b1 || bus2.mem_addr !== 8'hFF) begin errors++; $display("FAIL wrap_ff req=%b addr=%h exp=1,ff", bus2.mem_req, bus2.mem_addr); end
    tick();
    checks++; if (instr_valid2 !== 1'b1 || pc2 !== 8'h00) begin errors++; $display("FAIL wrap_pc_wrap valid=%b pc=%h exp=1,00", instr_valid2, pc2); end
    tick();
    checks++; if (bus2.mem_req !== 1'b1 || bus2.mem_addr !== 8'h00) begin errors++; $display("FAIL wrap_00 req=%b addr=%h exp=1,00", bus2.mem_req, bus2.mem_addr); end
    run2 = 1'b0;
    tick();
    checks++; if (instr_valid2 !== 1'b1 || pc2 !== 8'h01) begin errors++; $display("FAIL stop_decode valid=%b pc=%h exp=1,01", instr_valid2, pc2); end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (bus2.mem_req !== 1'b0 || instr_valid2 !== 1'b0 || pc2 !== 8'h01) begin errors++; $display("FAIL stop_idle cyc=%0d req=%b valid=%b pc=%h exp=0,0,01", i, bus2.mem_req, instr_valid2, pc2); end
    end
  endtask

  task automatic test_reset_mid_operand();
    clear_mem();
    mem[0] = 8'h01;
    mem[1] = 8'h33;
    lat = 0;
    ready_en = 1'b1;
    do_reset();
    run = 1'b1;
    tick();
    tick();
    ready_en = 1'b0;
    tick();
    tick();
    checks++; if (bus1.mem_req !== 1'b1 || bus1.mem_addr !== 8'h01 || pc !== 8'h01) begin errors++; $display("FAIL rstop_wait req=%b addr=%h pc=%h exp=1,01,01", bus1.mem_req, bus1.mem_addr, pc); end
    RST = 1'b1;
    tick();
    checks++; if (bus1.mem_req !== 1'b0 || pc !== 8'h00 || instr !== 8'h00) begin errors++; $display("FAIL rstop_after req=%b pc=%h ir=%h exp=0,00,00", bus1.mem_req, pc, instr); end
    RST = 1'b0;
    run = 1'b0;
    ready_force = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (bus1.mem_req !== 1'b0 || pc !== 8'h00) begin errors++; $display("FAIL rstop_late_ready cyc=%0d req=%b pc=%h exp=0,00", i, bus1.mem_req, pc); end
    end
    ready_force = 1'b0;
    ready_en = 1'b1;
  endtask

  task automatic test_timeout();
    clear_mem();
    mem[0] = 8'h5A;
    ready_en = 1'b0;
    do_reset();
    run = 1'b1;
`ifdef AY8_FETCH_TIMEOUT_EN
    for (int i = 1; i <= 16; i++) begin
      tick();
      checks++; if (bus1.mem_req !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL tmo_wait cyc=%0d req=%b err=%b exp=1,0", i, bus1.mem_req, err); end
    end
    tick();
    checks++; if (err !== 1'b1 || bus1.mem_req !== 1'b0) begin errors++; $display("FAIL tmo_err err=%b req=%b exp=1,0", err, bus1.mem_req); end
    ready_force = 1'b1;
    tick();
    checks++; if (err !== 1'b1 || bus1.mem_req !== 1'b0) begin errors++; $display("FAIL tmo_sticky err=%b req=%b exp=1,0", err, bus1.mem_req); end
    do_reset();
    run = 1'b1;
    for (int i = 1; i <= 16; i++) tick();
    ready_force = 1'b1;
    tick();
    ready_force = 1'b0;
    checks++; if (err !== 1'b0 || instr_valid !== 1'b1 || instr !== 8'h5A) begin errors++; $display("FAIL tmo_ready_wins err=%b valid=%b ir=%h exp=0,1,5a", err, instr_valid, instr); end
`else
    for (int i = 1; i <= 120; i++) begin
      tick();
      checks++; if (bus1.mem_req !== 1'b1 || bus1.mem_addr !== 8'h00 || err !== 1'b0) begin errors++; $display("FAIL tmo_unbounded cyc=%0d req=%b addr=%h err=%b exp=1,00,0", i, bus1.mem_req, bus1.mem_addr, err); end
    end
`endif
    run = 1'b0;
    ready_en = 1'b1;
  endtask

  initial begin
    RST = 1'b1;
    run = 1'b0;
    run2 = 1'b0;
    lat = 0;
    ready_en = 1'b1;
    ready_force = 1'b0;
    clear_mem();
    tick();
    test_reset();
    test_basic();
    test_wait_states();
    test_jump();
    test_wrap_stop();
    test_reset_mid_operand();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ay8_fetch_sequencer.md
# ay8_fetch_sequencer

Parametrised instruction-fetch sequencer for the AY8 CPU. It is the next generation of the two-state NOP fetch loop. It drives a request/ready memory port instead of a shared tri-state bus, and tolerates memory wait states. It decodes three control opcodes: NOP, JMP with an immediate operand, and HLT. Every fetched opcode is presented to the downstream execute stage through a one-cycle valid strobe.

## Interface
- ADDR_W, 8, program-counter and memory address width (1..16)
- DATA_W, 8, instruction/memory data width (≥8; opcode = low 8 bits)
- RESET_PC, 0, PC value loaded on reset (ADDR_W bits)
- TIMEOUT, 16, max cycles `mem_req` may wait for `mem_ready` (only with `AY8_FETCH_TIMEOUT_EN`)
- CLK  in  1  clock; all state changes on posedge
- RST  in  1  reset; one clock, reset is synchronous and active-high
- run  in  1  level; 1 = fetch/execute, 0 = stop at next instruction boundary
- mem_req  out  1  memory read request
- mem_addr  out  ADDR_W  read address; valid while `mem_req`=1
- mem_rdata  in  DATA_W  read data; sampled only when `mem_req`=1 and `mem_ready`=1
- mem_ready  in  1  memory completion strobe
- instr  out  DATA_W  registered instruction word (IR)
- instr_valid  out  1  one-cycle strobe: `instr` holds a newly decoded opcode
- pc  out  ADDR_W  current program counter
- halted  out  1  1 while in HALT
- err  out  1  1 while in ERR (tied 0 without macro)

## Operation
- States: IDLE, FETCH, DECODE, OPERAND, HALT, ERR.
- `mem_req`, `halted` and `err` decode combinationally from state. `mem_addr` = `pc`.
- IDLE: `mem_req`=0. If `run`=1, go to FETCH.
- FETCH: `mem_req`=1. On `mem_ready`=1: IR <= `mem_rdata`, `pc` <= `pc`+1, go to DECODE. Otherwise hold, with address stable.
- DECODE: `instr_valid`=1 for exactly this cycle. Next state depends on `instr[7:0]`:
  - 8'hFF (HLT): go to HALT.
  - 8'h01 (JMP): go to OPERAND.
  - any other (incl. 8'h00 NOP): go to FETCH if `run`=1, else IDLE.
- OPERAND: `mem_req`=1. On `mem_ready`=1: `pc` <= `mem_rdata[ADDR_W-1:0]`, zero-extended if ADDR_W>DATA_W. Then go to FETCH if `run`=1, else IDLE. IR is unchanged.
- HALT: sticky. Only RST exits. `mem_req`=0.
- ERR: sticky. Only RST exits. `mem_req`=0.
- PC arithmetic is modulo 2^ADDR_W: all-ones +1 = 0, with no flag.
- `mem_ready` outside FETCH/OPERAND is ignored.
- `run` deasserted mid-fetch: the current access and the DECODE/OPERAND step complete, then the block enters IDLE. No access is aborted.

## Timing
- Reset (RST high at a posedge) gives, from the next cycle:
  - state IDLE, `pc`=RESET_PC, IR=0
  - `mem_req`=0, `instr_valid`=0, `halted`=0, `err`=0
- RST has priority over all transitions, including mid-wait FETCH/OPERAND. The pending access is abandoned; late `mem_ready` is ignored.
- Zero-wait memory (`mem_ready` high in the first request cycle): 2 cycles per single-byte instruction (FETCH, DECODE); JMP takes 3 cycles (FETCH, DECODE, OPERAND).
- Each wait cycle extends FETCH/OPERAND by exactly 1 cycle.
- IDLE→FETCH: one cycle after `run` is first sampled high.
- `instr_valid` is never high in two consecutive cycles.

## Configuration
- `AY8_FETCH_TIMEOUT_EN` defined:
  - A wait counter clears on entry to FETCH/OPERAND and increments each cycle `mem_req`=1 and `mem_ready`=0.
  - When it reaches TIMEOUT, the next state is ERR and `err`=1.
  - `mem_ready` in the same cycle the count reaches TIMEOUT wins: normal completion.
- Undefined: no counter, no ERR state. Waits are unbounded; `err` is constant 0.

## Test plan
- Basic run: RST, then `run`=1; mem[0..2]=00,00,FF, ready always high → addresses 0,1,2; 3 `instr_valid` pulses, 2 cycles apart; `halted`=1, `pc`=3.
- Wait states: `mem_ready` delayed 3 cycles per access → `mem_req` held 4 cycles with `mem_addr` stable; IR loaded only on the ready cycle.
- Jump: mem[0]=01, mem[1]=10, mem[0x10]=FF → addresses 0,1,0x10; `instr_valid` for 01 and FF only; final `pc`=0x11, `halted`=1.
- Wrap and stop: RESET_PC=0xFE, all NOP → addresses FE,FF,00. `run` dropped during FETCH @00 → DECODE completes, then IDLE with `mem_req`=0, `pc`=01.
- Reset mid-OPERAND: RST pulsed while waiting for operand → next cycle IDLE, `pc`=RESET_PC, `mem_req`=0; a late `mem_ready` does not change `pc`.
- Timeout (TIMEOUT=16): `mem_ready` never asserted → with macro, `err`=1 after 16 wait cycles and `mem_req`=0 thereafter. Without macro, `mem_req` stays 1 for 100+ cycles and `err`=0.
